mac_mdc_compute_sequencer: RTL and testbench

Job-level sequencer between the HWPE controller and the `multi_dataflow_mac_mdc` kernel adapter. It accepts one job trigger carrying an output-element count. It issues per-element start pulses to the adapter, driven by the adapter's ready flag, and counts the adapter's per-output done pulses. When the programmed number of outputs has been produced, it raises a single end-of-job pulse. It replaces ad-hoc start generation in the engine and gives the controller one clean busy/done/err view.

---
 rtl/mac_mdc_compute_sequencer_pkg.sv | 27 ++
 rtl/mac_mdc_compute_sequencer_watchdog.sv | 31 +++
 rtl/mac_mdc_compute_sequencer.sv | 145 ++++++++++++++
 tb/tb_mac_mdc_compute_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_mdc_compute_sequencer_pkg.sv
// Shared types and constants for the MAC MDC compute sequencer and its
// controller/engine glue.
package multi_dataflow_mac_mdc_package;

   localparam int unsigned MAC_MDC_SEQ_CNT_W        = 16;
   localparam int unsigned MAC_MDC_SEQ_TIMEOUT_DFLT = 1024;

   typedef enum logic [1:0] {
      SEQ_IDLE    = 2'd0,
      SEQ_ISSUE   = 2'd1,
      SEQ_COMPUTE = 2'd2,
      SEQ_DONE    = 2'd3
   } mac_mdc_seq_state_t;

   typedef struct packed {
      logic                         start;
      logic [MAC_MDC_SEQ_CNT_W-1:0] n_outputs;
   } ctrl_sequencer_mac_mdc_t;

   typedef struct packed {
      logic                         busy;
      logic                         done;
      logic                         err;
      logic [MAC_MDC_SEQ_CNT_W-1:0] cnt_out;
   } flags_sequencer_mac_mdc_t;

endpackage

// File: rtl/mac_mdc_compute_sequencer_watchdog.sv
// Stall watchdog: counts cycles while a job runs, restarts on every output,
// and flags a timeout once TIMEOUT_CYCLES cycles pass without progress.
module mac_mdc_seq_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic run_i,
   input  logic kick_i,
   output logic timeout_o
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i || !run_i || kick_i) begin
         cnt_q <= '0;
      end else if (!timeout_o) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   // Fires in the last counted cycle so the job ends exactly TIMEOUT_CYCLES after it began.
   assign timeout_o = run_i && (cnt_q >= W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mac_mdc_compute_sequencer.sv
// Job-level sequencer issuing per-element starts to the MAC MDC adapter and
// counting its outputs. Optional watchdog: define MAC_MDC_SEQ_WATCHDOG_EN.
module mac_mdc_compute_sequencer
   import multi_dataflow_mac_mdc_package::*;
#(
   parameter int unsigned CNT_W          = MAC_MDC_SEQ_CNT_W,
   parameter int unsigned TIMEOUT_CYCLES = MAC_MDC_SEQ_TIMEOUT_DFLT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] n_outputs_i,
   output logic             kernel_start_o,
   input  logic             kernel_ready_i,
   input  logic             kernel_done_i,
   input  logic             kernel_idle_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] cnt_out_o,
   output logic [1:0]       state_o
);

   mac_mdc_seq_state_t state_q, state_d;
   logic [CNT_W-1:0]   n_tgt_q, n_tgt_d;
   logic [CNT_W-1:0]   issued_q, issued_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc;
   logic               ready_q;
   logic               count_done;
   logic               timeout;
   logic               wd_fire;
   logic               unused_ok;

   // Saturating output count including this cycle's done pulse.
   assign count_done = kernel_done_i && (cnt_q != n_tgt_q);
   assign cnt_inc    = cnt_q + {{(CNT_W-1){1'b0}}, count_done};

   always_comb begin
      state_d  = state_q;
      n_tgt_d  = n_tgt_q;
      issued_d = issued_q;
      cnt_d    = cnt_q;
      wd_fire  = 1'b0;
      case (state_q)
         SEQ_IDLE: begin
            if (start_i) begin
               n_tgt_d  = n_outputs_i;
               issued_d = '0;
               cnt_d    = '0;
               // An empty job still spends one busy cycle before DONE.
               state_d  = (n_outputs_i != '0) ? SEQ_ISSUE : SEQ_COMPUTE;
            end
         end
         SEQ_ISSUE: begin
            issued_d = issued_q + CNT_W'(1);
            cnt_d    = cnt_inc;
            state_d  = SEQ_COMPUTE;
         end
         SEQ_COMPUTE: begin
            cnt_d = cnt_inc;
            if (cnt_inc == n_tgt_q) begin
               state_d = SEQ_DONE;
            end else if (timeout) begin
               wd_fire = 1'b1;
               state_d = SEQ_DONE;
            end else if (ready_q && (issued_q < n_tgt_q)) begin
               state_d = SEQ_ISSUE;
            end
         end
         SEQ_DONE: begin
            state_d = SEQ_IDLE;
         end
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase
   end

   // ready is registered so the next start lands two cycles after it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= SEQ_IDLE;
         n_tgt_q  <= '0;
         issued_q <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
      end else if (clear_i) begin
         state_q  <= SEQ_IDLE;
         n_tgt_q  <= '0;
         issued_q <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_tgt_q  <= n_tgt_d;
         issued_q <= issued_d;
         cnt_q    <= cnt_d;
         ready_q  <= kernel_ready_i;
      end
   end

`ifdef MAC_MDC_SEQ_WATCHDOG_EN
   logic err_q;

   mac_mdc_seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .run_i    (busy_o),
      .kick_i   (kernel_done_i),
      .timeout_o(timeout)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (clear_i) begin
         err_q <= 1'b0;
      end else if ((state_q == SEQ_IDLE) && start_i) begin
         err_q <= 1'b0;
      end else if (wd_fire) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   assign kernel_start_o = (state_q == SEQ_ISSUE);
   assign done_o         = (state_q == SEQ_DONE);
   assign busy_o         = (state_q == SEQ_ISSUE) || (state_q == SEQ_COMPUTE);
   assign cnt_out_o      = cnt_q;
   assign state_o        = state_q;

   // kernel_idle_i is status only.
   assign unused_ok = ^{kernel_idle_i, wd_fire, (TIMEOUT_CYCLES == 0)};

endmodule

// File: tb/tb_mac_mdc_compute_sequencer.sv
// Bench for mac_mdc_compute_sequencer: adapter model, job-level reference
// expectations, directed and randomized jobs; watchdog step under MAC_MDC_SEQ_WATCHDOG_EN.
module tb_mac_mdc_compute_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clear_i = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] n_outputs_i = '0;
   logic        kernel_start_o;
   logic        kernel_ready_i = 1'b0;
   logic        kernel_done_i = 1'b0;
   logic        kernel_idle_i = 1'b1;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [15:0] cnt_out_o;
   logic [1:0]  state_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // adapter model controls and monitor records
   int rdly = 3;
   int ddly = 2;
   bit rand_mode = 1'b0;
   bit stall = 1'b0;
   int ready_at[$];
   int done_at[$];
   int start_cnt = 0;
   int done_cnt = 0;
   int done_o_cyc = -1;
   int last_kdone_cyc = -1;
   int start_cyc = 0;

   logic [15:0] exp_q[$];

   mac_mdc_compute_sequencer #(
      .CNT_W         (16),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .start_i       (start_i),
      .n_outputs_i   (n_outputs_i),
      .kernel_start_o(kernel_start_o),
      .kernel_ready_i(kernel_ready_i),
      .kernel_done_i (kernel_done_i),
      .kernel_idle_i (kernel_idle_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .cnt_out_o     (cnt_out_o),
      .state_o       (state_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // adapter model and output monitor, evaluated mid-cycle
   always @(negedge clk_i) begin
      int rd;
      int dd;
      if (!rst_ni || clear_i) begin
         ready_at.delete();
         done_at.delete();
      end else if (kernel_start_o) begin
         start_cnt++;
         if (!stall) begin
            rd = rand_mode ? $urandom_range(4, 1) : rdly;
            dd = rand_mode ? $urandom_range(2, 0) : ddly;
            ready_at.push_back(cyc + rd);
            done_at.push_back(cyc + rd + dd);
         end
      end
      if (done_o) begin
         done_cnt++;
         done_o_cyc = cyc;
      end
      kernel_ready_i = 1'b0;
      kernel_done_i  = 1'b0;
      if (ready_at.size() > 0 && ready_at[0] == cyc) begin
         kernel_ready_i = 1'b1;
         void'(ready_at.pop_front());
      end
      if (done_at.size() > 0 && done_at[0] == cyc) begin
         kernel_done_i  = 1'b1;
         last_kdone_cyc = cyc;
         void'(done_at.pop_front());
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
      #1;
   endtask

   // driver: pulse start for one cycle; the model expects n outputs
   task automatic start_job(input int n);
      start_i     = 1'b1;
      n_outputs_i = 16'(n);
      start_cyc   = cyc;
      start_cnt   = 0;
      exp_q.push_back(16'(n));
      step();
      start_i = 1'b0;
   endtask

   // scoreboard: wait for end of job and compare against the job-level model
   task automatic wait_job(input string tag, input int n);
      int k;
      int d0;
      logic [15:0] exp_cnt;
      d0 = done_cnt;
      k  = 0;
      while (!done_o && k < 2000) begin
         step();
         k++;
      end
      check({tag, " done_seen"}, 32'(k < 2000), 1);
      exp_cnt = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hffff;
      check({tag, " cnt_out"}, 32'(cnt_out_o), 32'(exp_cnt));
      check({tag, " starts"}, start_cnt, n);
      check({tag, " busy_at_done"}, 32'(busy_o), 0);
      check({tag, " err"}, 32'(err_o), 0);
      check({tag, " done_latency"}, done_o_cyc, last_kdone_cyc + 1);
      repeat (4) step();
      check({tag, " done_pulses"}, done_cnt - d0, 1);
      check({tag, " no_extra_start"}, start_cnt, n);
      check({tag, " idle_state"}, 32'(state_o), 0);
   endtask

   initial begin
      int n;
      int k;
      int d0;
      logic [15:0] exp_cnt;

      // reset
      repeat (3) step();
      check("rst state", 32'(state_o), 0);
      check("rst busy", 32'(busy_o), 0);
      check("rst done", 32'(done_o), 0);
      check("rst kstart", 32'(kernel_start_o), 0);
      check("rst err", 32'(err_o), 0);
      check("rst cnt", 32'(cnt_out_o), 0);
      rst_ni = 1'b1;
      repeat (2) step();

      // four-element job, ready 3 after start, done 2 after ready
      rdly = 3; ddly = 2;
      start_job(4);
      check("job4 kstart_t1", 32'(kernel_start_o), 1);
      check("job4 busy_t1", 32'(busy_o), 1);
      wait_job("job4", 4);

      // ready-to-start latency of two cycles
      start_job(2);
      k = 0;
      while (!kernel_ready_i && k < 50) begin step(); k++; end
      n = cyc;
      step();
      check("rdy_lat t1_no_start", 32'(kernel_start_o), 0);
      step();
      check("rdy_lat t2_start", 32'(kernel_start_o), 1);
      check("rdy_lat cyc", cyc, n + 2);
      wait_job("job2", 2);

      // empty job
      d0 = done_cnt;
      start_job(0);
      check("job0 busy_t1", 32'(busy_o), 1);
      check("job0 done_t1", 32'(done_o), 0);
      step();
      check("job0 done_t2", 32'(done_o), 1);
      check("job0 busy_t2", 32'(busy_o), 0);
      exp_cnt = exp_q.pop_front();
      check("job0 cnt", 32'(cnt_out_o), 32'(exp_cnt));
      repeat (3) step();
      check("job0 starts", start_cnt, 0);
      check("job0 done_pulses", done_cnt - d0, 1);

      // ready and done coincide on the last element
      rdly = 2; ddly = 0;
      start_job(2);
      wait_job("same_cycle", 2);

      // start reissued mid-job is ignored
      rdly = 3; ddly = 2;
      start_job(3);
      step(); step();
      start_i = 1'b1;
      n_outputs_i = 16'd9;
      step();
      start_i = 1'b0;
      wait_job("restart_ignored", 3);

      // clear after two of five outputs
      d0 = done_cnt;
      start_job(5);
      k = 0;
      while (cnt_out_o != 16'd2 && k < 200) begin step(); k++; end
      check("clear reached2", 32'(k < 200), 1);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      void'(exp_q.pop_front());
      check("clear state", 32'(state_o), 0);
      check("clear cnt", 32'(cnt_out_o), 0);
      check("clear busy", 32'(busy_o), 0);
      check("clear err", 32'(err_o), 0);
      repeat (12) step();
      check("clear no_done", done_cnt - d0, 0);
      start_job(1);
      wait_job("after_clear", 1);

      // randomized jobs
      rand_mode = 1'b1;
      for (int j = 0; j < 8; j++) begin
         n = $urandom_range(8, 1);
         start_job(n);
         wait_job("rand", n);
      end
      rand_mode = 1'b0;

`ifdef MAC_MDC_SEQ_WATCHDOG_EN
      // stalled kernel ends the job with err after 16 cycles
      stall = 1'b1;
      d0 = done_cnt;
      start_job(3);
      k = 0;
      while (!done_o && k < 200) begin step(); k++; end
      check("wd done_seen", 32'(k < 200), 1);
      check("wd latency", cyc, start_cyc + 1 + 16);
      check("wd err", 32'(err_o), 1);
      check("wd busy", 32'(busy_o), 0);
      check("wd cnt", 32'(cnt_out_o), 0);
      void'(exp_q.pop_front());
      repeat (3) step();
      check("wd err_sticky", 32'(err_o), 1);
      check("wd done_pulses", done_cnt - d0, 1);
      stall = 1'b0;
      start_job(1);
      check("wd err_cleared", 32'(err_o), 0);
      wait_job("wd_recover", 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
